ss_sequencer: RTL and testbench
===============================

Name: ss_sequencer

Overview:
Multi-cycle control sequencer for the minimal RISC-V core datapath (instruction register, ALU, register file, shared RAM port).
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Handshakes with the single shared RAM port.
- Generates IR load, PC load/select, RAM request/write and register write strobes.
- Traps on illegal opcodes and bus timeouts; counts retired instructions.

Parameters:
WAIT_LIMIT, 16, max cycles waiting for mem_ready per RAM access; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset; synchronous, active-low
run  in  1  enable; sampled in IDLE and at instruction boundaries
opcode  in  7  instruction[6:0] from IR
branch_taken  in  1  branch condition from ALU status/branch logic; valid in EXECUTE
mem_ready  in  1  RAM handshake acknowledge
mem_req  out  1  RAM access request
mem_we  out  1  1 = store, 0 = read
ifetch  out  1  RAM address mux select: 1 = PC, 0 = ALU result
ir_load  out  1  load IR from RAM data
pc_load  out  1  update PC
pc_sel  out  1  0 = PC+4, 1 = branch/jump target
reg_write  out  1  register file write enable
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WB=5 TRAP=7
trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state=IDLE, wait counter=0, instret=0, trap_cause=00.
  - All strobes are 0 while in IDLE.
  - Reset mid-access drops mem_req on the next cycle.
- Strobes are decoded from state, combinationally:
  - mem_req=1 in FETCH and MEM.
  - ifetch=1 in FETCH only.
  - mem_we=1 in MEM for STORE only.
  - ir_load = FETCH & mem_ready.
  - reg_write=1 in WB.
- Legal opcodes:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011.
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - The opcode class is latched in DECODE.
- Transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: mem_ready=1 -> DECODE; else remain.
  - DECODE (1 cycle): legal -> EXECUTE; illegal -> TRAP with cause 01.
  - EXECUTE (1 cycle):
    - LOAD/STORE -> MEM.
    - BRANCH -> boundary, with pc_load=1, pc_sel=branch_taken.
    - Others -> WB.
  - MEM: on mem_ready=1, LOAD -> WB; STORE -> boundary with pc_load=1, pc_sel=0.
  - WB (1 cycle): pc_load=1; pc_sel=1 for JAL/JALR, else 0; -> boundary.
  - Boundary: next state FETCH if run=1, else IDLE. run is ignored mid-instruction; the instruction always completes.
  - TRAP: all strobes 0; held until rst_n.
- Latency with zero-wait RAM:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- instret increments by 1 in every cycle where pc_load=1 and wraps modulo 2^CNT_W.
- Exactly one pc_load per retired instruction; none for trapped instructions.
- Timeout (WAIT_LIMIT>0):
  - Wait counter clears on entry to FETCH/MEM and counts cycles with mem_ready=0.
  - If mem_ready=0 in the WAIT_LIMIT-th cycle of the access -> TRAP, cause 10.
  - mem_ready=1 in that same cycle completes the access normally (ready wins).
  - WAIT_LIMIT=0: wait indefinitely.

Optional Feature:
SEQ_STEP_EN:
- Defined:
  - Adds input port step (1 bit).
  - IDLE -> FETCH on run|step.
  - An instruction started by step with run=0 returns to IDLE at its boundary regardless of run.
  - step is ignored outside IDLE.
- Undefined: no step port; behaviour exactly as above.

Test Plan:
- rst_n 0->1, run=1, opcode 0110011, mem_ready=1 always -> state 1,2,3,5,1; reg_write one cycle in WB; pc_load with pc_sel=0; instret=1.
- opcode 0000011, mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles with mem_req=1, mem_we=0; then WB; instret=1.
- opcode 1100011, branch_taken=1 -> EXECUTE asserts pc_load, pc_sel=1; no reg_write; next state FETCH. Repeat with branch_taken=0 -> pc_sel=0.
- opcode 0000000 -> DECODE->TRAP; trap_cause=01; no pc_load; stays in TRAP for 20 cycles despite run; rst_n low -> IDLE, instret=0.
- WAIT_LIMIT=4, mem_ready=0 in FETCH -> TRAP after 4 FETCH cycles, cause 10. Rerun with mem_ready=1 in 4th cycle -> DECODE, no trap.
- run dropped in EXECUTE of a store -> store completes, pc_load, then IDLE. rst_n low during MEM wait -> IDLE next cycle, mem_req=0.

Source files
------------

// File: rtl/ss_sequencer_if.sv
// Shared RAM port handshake between the control sequencer (master) and the memory (slave).
interface ss_sequencer_if ();
   logic mem_req;
   logic mem_we;
   logic ifetch;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output ifetch, input mem_ready);
   modport slave  (input mem_req, input mem_we, input ifetch, output mem_ready);
endinterface

// File: rtl/ss_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer with trap and retire counting.
// Optional single-step input enabled by defining SEQ_STEP_EN.
module ss_sequencer #(
   parameter int unsigned WAIT_LIMIT = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
`ifdef SEQ_STEP_EN
   input  logic             step,
`endif
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   ss_sequencer_if.master   mem,
   output logic             ir_load,
   output logic             pc_load,
   output logic             pc_sel,
   output logic             reg_write,
   output logic [2:0]       state,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFetch   = 3'd1,
      StDecode  = 3'd2,
      StExecute = 3'd3,
      StMem     = 3'd4,
      StWb      = 3'd5,
      StTrap    = 3'd7
   } state_e;

   typedef enum logic [2:0] {ClsOther, ClsLoad, ClsStore, ClsBranch, ClsJump} cls_e;

   localparam int unsigned WaitW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d, opc_cls;
   logic [1:0]       cause_q, cause_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             opc_legal, wait_hit, boundary, go, step_hold;
   logic             mem_req, mem_we, ifetch;

`ifdef SEQ_STEP_EN
   // Remembers that the current instruction was launched by step alone.
   logic step_q, step_d;
   assign go        = run | step;
   assign step_hold = step_q;
   assign step_d    = (state_q == StIdle) ? ~run : step_q;
   always_ff @(posedge clk) begin
      if (!rst_n) step_q <= 1'b0;
      else        step_q <= step_d;
   end
`else
   assign go        = run;
   assign step_hold = 1'b0;
`endif

   always_comb begin
      opc_cls   = ClsOther;
      opc_legal = 1'b1;
      case (opcode)
         7'b0000011: opc_cls = ClsLoad;
         7'b0100011: opc_cls = ClsStore;
         7'b1100011: opc_cls = ClsBranch;
         7'b1101111, 7'b1100111: opc_cls = ClsJump;
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: opc_cls = ClsOther;
         default: opc_legal = 1'b0;
      endcase
   end

   // Last permitted cycle of an access; ready in this cycle still completes it.
   assign wait_hit = (WAIT_LIMIT != 0) && (wait_q == WaitLast);

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      cause_d   = cause_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ifetch    = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_sel    = 1'b0;
      reg_write = 1'b0;
      boundary  = 1'b0;
      unique case (state_q)
         StIdle: if (go) state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            ifetch  = 1'b1;
            ir_load = mem.mem_ready;
            if (mem.mem_ready) state_d = StDecode;
            else if (wait_hit) begin
               state_d = StTrap;
               cause_d = 2'b10;
            end
         end
         StDecode: begin
            cls_d = opc_cls;
            if (opc_legal) state_d = StExecute;
            else begin
               state_d = StTrap;
               cause_d = 2'b01;
            end
         end
         StExecute: begin
            case (cls_q)
               ClsLoad, ClsStore: state_d = StMem;
               ClsBranch: begin
                  pc_load  = 1'b1;
                  pc_sel   = branch_taken;
                  boundary = 1'b1;
               end
               default: state_d = StWb;
            endcase
         end
         StMem: begin
            mem_req = 1'b1;
            mem_we  = (cls_q == ClsStore);
            if (mem.mem_ready) begin
               if (cls_q == ClsStore) begin
                  pc_load  = 1'b1;
                  boundary = 1'b1;
               end else begin
                  state_d = StWb;
               end
            end else if (wait_hit) begin
               state_d = StTrap;
               cause_d = 2'b10;
            end
         end
         StWb: begin
            reg_write = 1'b1;
            pc_load   = 1'b1;
            pc_sel    = (cls_q == ClsJump);
            boundary  = 1'b1;
         end
         StTrap: state_d = StTrap;
         default: state_d = StIdle;
      endcase
      if (boundary) state_d = (run && !step_hold) ? StFetch : StIdle;
   end

   always_comb begin
      wait_d = '0;
      if ((state_q == StFetch || state_q == StMem) && !mem.mem_ready && WAIT_LIMIT != 0) begin
         wait_d = wait_q + 1'b1;
      end
   end

   assign instret_d = instret_q + CNT_W'(pc_load);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cls_q     <= ClsOther;
         cause_q   <= 2'b00;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         cause_q   <= cause_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
      end
   end

   assign mem.mem_req = mem_req;
   assign mem.mem_we  = mem_we;
   assign mem.ifetch  = ifetch;
   assign state       = state_q;
   assign trap_cause  = cause_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_ss_sequencer.sv
// Directed bench for ss_sequencer: WAIT_LIMIT=4 main instance plus a WAIT_LIMIT=0 shadow.
module tb_ss_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_ready = 1'b1;
   logic [6:0]  opcode = 7'd0;
`ifdef SEQ_STEP_EN
   logic        step = 1'b0;
`endif

   logic        ir_load, pc_load, pc_sel, reg_write;
   logic [2:0]  state;
   logic [1:0]  trap_cause;
   logic [31:0] instret;
   logic        nt_ir_load, nt_pc_load, nt_pc_sel, nt_reg_write;
   logic [2:0]  nt_state;
   logic [1:0]  nt_trap_cause;
   logic [31:0] nt_instret;
   logic [9:0]  obs, nt_obs;

   int checks = 0;
   int failures = 0;

   // {state, mem_req, mem_we, ifetch, ir_load, pc_load, pc_sel, reg_write}
   localparam logic [9:0] E_IDLE = {3'd0, 7'b0000000};
   localparam logic [9:0] E_FR   = {3'd1, 7'b1011000};
   localparam logic [9:0] E_FW   = {3'd1, 7'b1010000};
   localparam logic [9:0] E_DEC  = {3'd2, 7'b0000000};
   localparam logic [9:0] E_EXE  = {3'd3, 7'b0000000};
   localparam logic [9:0] E_BRT  = {3'd3, 7'b0000110};
   localparam logic [9:0] E_BRN  = {3'd3, 7'b0000100};
   localparam logic [9:0] E_ML   = {3'd4, 7'b1000000};
   localparam logic [9:0] E_MSW  = {3'd4, 7'b1100000};
   localparam logic [9:0] E_MSR  = {3'd4, 7'b1100100};
   localparam logic [9:0] E_WB   = {3'd5, 7'b0000101};
   localparam logic [9:0] E_WBJ  = {3'd5, 7'b0000111};
   localparam logic [9:0] E_TRAP = {3'd7, 7'b0000000};

   ss_sequencer_if mif ();
   ss_sequencer_if nif ();
   assign mif.mem_ready = mem_ready;
   assign nif.mem_ready = mem_ready;

   ss_sequencer #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
`ifdef SEQ_STEP_EN
      .step         (step),
`endif
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem          (mif),
      .ir_load      (ir_load),
      .pc_load      (pc_load),
      .pc_sel       (pc_sel),
      .reg_write    (reg_write),
      .state        (state),
      .trap_cause   (trap_cause),
      .instret      (instret)
   );

   ss_sequencer #(.WAIT_LIMIT(0), .CNT_W(32)) dut_nt (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
`ifdef SEQ_STEP_EN
      .step         (step),
`endif
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem          (nif),
      .ir_load      (nt_ir_load),
      .pc_load      (nt_pc_load),
      .pc_sel       (nt_pc_sel),
      .reg_write    (nt_reg_write),
      .state        (nt_state),
      .trap_cause   (nt_trap_cause),
      .instret      (nt_instret)
   );

   assign obs    = {state, mif.mem_req, mif.mem_we, mif.ifetch, ir_load, pc_load, pc_sel,
                    reg_write};
   assign nt_obs = {nt_state, nif.mem_req, nif.mem_we, nif.ifetch, nt_ir_load, nt_pc_load,
                    nt_pc_sel, nt_reg_write};

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in IDLE with rst_n released, just after a rising edge.
   task automatic apply_reset;
      rst_n = 1'b0;
      run = 1'b0;
      mem_ready = 1'b1;
      branch_taken = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      run = 1'b1;
      opcode = 7'b0110011;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if (obs !== E_IDLE) begin
         failures++;
         $display("FAIL reset_strobes obs=%b exp=%b", obs, E_IDLE);
      end
      checks++;
      if (instret !== 32'd0 || trap_cause !== 2'b00) begin
         failures++;
         $display("FAIL reset_regs instret=%0d cause=%b exp 0/00", instret, trap_cause);
      end
      next_cycle();
   endtask

   task automatic test_alu;
      logic [9:0] ev [6];
      ev = '{E_IDLE, E_FR, E_DEC, E_EXE, E_WB, E_FR};
      apply_reset();
      run = 1'b1;
      opcode = 7'b0110011;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL alu cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (instret !== 32'd1) begin
         failures++;
         $display("FAIL alu_instret got=%0d exp=1", instret);
      end
   endtask

   task automatic test_load;
      logic [9:0] ev [10];
      logic       rv [10];
      ev = '{E_IDLE, E_FR, E_DEC, E_EXE, E_ML, E_ML, E_ML, E_ML, E_WB, E_FR};
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      apply_reset();
      run = 1'b1;
      opcode = 7'b0000011;
      for (int i = 0; i < 10; i++) begin
         mem_ready = rv[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL load cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (instret !== 32'd1 || trap_cause !== 2'b00) begin
         failures++;
         $display("FAIL load_instret got=%0d cause=%b exp 1/00", instret, trap_cause);
      end
   endtask

   task automatic test_branch;
      logic [9:0] ev [8];
      logic       bv [8];
      ev = '{E_IDLE, E_FR, E_DEC, E_BRT, E_FR, E_DEC, E_BRN, E_FR};
      bv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      run = 1'b1;
      opcode = 7'b1100011;
      for (int i = 0; i < 8; i++) begin
         branch_taken = bv[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL branch cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (instret !== 32'd2) begin
         failures++;
         $display("FAIL branch_instret got=%0d exp=2", instret);
      end
   endtask

   task automatic test_jal;
      logic [9:0] ev [6];
      ev = '{E_IDLE, E_FR, E_DEC, E_EXE, E_WBJ, E_FR};
      apply_reset();
      run = 1'b1;
      opcode = 7'b1101111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL jal cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_illegal;
      logic [9:0] ev [4];
      logic       stay_bad;
      ev = '{E_IDLE, E_FR, E_DEC, E_TRAP};
      stay_bad = 1'b0;
      apply_reset();
      run = 1'b1;
      opcode = 7'b0000000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL illegal cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (trap_cause !== 2'b01) begin
         failures++;
         $display("FAIL illegal_cause got=%b exp=01", trap_cause);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (obs !== E_TRAP) stay_bad = 1'b1;
         next_cycle();
      end
      checks++;
      if (stay_bad !== 1'b0 || instret !== 32'd0) begin
         failures++;
         $display("FAIL trap_hold left_trap=%b instret=%0d exp 0/0", stay_bad, instret);
      end
      rst_n = 1'b0;
      next_cycle();
      checks++;
      if (state !== 3'd0 || trap_cause !== 2'b00 || instret !== 32'd0) begin
         failures++;
         $display("FAIL trap_reset state=%0d cause=%b instret=%0d exp 0/00/0", state,
                  trap_cause, instret);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_timeout;
      logic [9:0] ev [6];
      logic [9:0] ev2 [6];
      logic       rv2 [6];
      logic       nt_bad;
      ev  = '{E_IDLE, E_FW, E_FW, E_FW, E_FW, E_TRAP};
      ev2 = '{E_IDLE, E_FW, E_FW, E_FW, E_FR, E_DEC};
      rv2 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      nt_bad = 1'b0;
      apply_reset();
      run = 1'b1;
      opcode = 7'b0110011;
      mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL timeout cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (trap_cause !== 2'b10) begin
         failures++;
         $display("FAIL timeout_cause got=%b exp=10", trap_cause);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (nt_obs !== E_FW || nt_trap_cause !== 2'b00 || nt_instret !== 32'd0) nt_bad = 1'b1;
         next_cycle();
      end
      checks++;
      if (nt_bad !== 1'b0) begin
         failures++;
         $display("FAIL no_limit_wait obs=%b cause=%b exp=%b/00", nt_obs, nt_trap_cause, E_FW);
      end
      apply_reset();
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rv2[i];
         @(negedge clk);
         checks++;
         if (obs !== ev2[i]) begin
            failures++;
            $display("FAIL ready_wins cyc%0d obs=%b exp=%b", i, obs, ev2[i]);
         end
         next_cycle();
      end
      checks++;
      if (trap_cause !== 2'b00) begin
         failures++;
         $display("FAIL ready_wins_cause got=%b exp=00", trap_cause);
      end
   endtask

   task automatic test_store_drop;
      logic [9:0] ev [8];
      logic       rv [8];
      logic       uv [8];
      ev = '{E_IDLE, E_FR, E_DEC, E_EXE, E_MSW, E_MSR, E_IDLE, E_IDLE};
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      uv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      opcode = 7'b0100011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rv[i];
         run = uv[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL store_drop cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (instret !== 32'd1) begin
         failures++;
         $display("FAIL store_instret got=%0d exp=1", instret);
      end
   endtask

   task automatic test_reset_mid;
      logic [9:0] ev [8];
      logic       rv [8];
      logic       sv [8];
      ev = '{E_IDLE, E_FR, E_DEC, E_EXE, E_ML, E_ML, E_IDLE, E_FW};
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      apply_reset();
      run = 1'b1;
      opcode = 7'b0000011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rv[i];
         rst_n = sv[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL reset_mid cyc%0d obs=%b exp=%b", i, obs, ev[i]);
         end
         next_cycle();
      end
      checks++;
      if (instret !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_instret got=%0d exp=0", instret);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_branch();
      test_jal();
      test_illegal();
      test_timeout();
      test_store_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
